// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Debounces a raw asynchronous push-button into a clean level.
//               The input passes through a SYNC_STAGES-flop synchroniser. A
//               4-state FSM with a stability counter then qualifies each new
//               level over STABLE_CYCLES cycles before btn_level follows it.
//               When BUTTON_DEBOUNCER_AUTOREPEAT_EN is defined, holding the
//               button produces periodic single-cycle repeat_pulse strobes.
//               Otherwise repeat_pulse is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic busy,
    output logic repeat_pulse
);

    // The counter only ever needs to reach STABLE_CYCLES-1, so it cannot wrap.
    localparam int c_cnt_w = ($clog2(STABLE_CYCLES) < 1) ? 1 : $clog2(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE_LOW  = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_IDLE_HIGH = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;

    // Metastability synchroniser: the only logic that samples btn_raw.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // State and stability counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic. A bounce has priority over the terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_IDLE_LOW: begin
                if (w_sync) w_state_nxt = ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = ST_IDLE_LOW;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_IDLE_HIGH;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_IDLE_HIGH: begin
                if (!w_sync) w_state_nxt = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (w_sync) begin
                    w_state_nxt = ST_IDLE_HIGH;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_IDLE_LOW;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE_LOW;
            end
        endcase
    end

    // Registered level and busy flags, decoded from the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_level <= 1'b0;
            busy      <= 1'b0;
        end else begin
            btn_level <= (r_state == ST_IDLE_HIGH) || (r_state == ST_WAIT_LOW);
            busy      <= (r_state == ST_WAIT_HIGH) || (r_state == ST_WAIT_LOW);
        end
    end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_rep_w   = $clog2(c_rep_max + 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic               r_rep_first;
    logic [c_rep_w-1:0] w_rep_target;
    logic               w_rep_hold;

    // The first strobe waits REPEAT_DELAY cycles; later strobes use REPEAT_PERIOD.
    assign w_rep_target = r_rep_first ? c_rep_w'(REPEAT_DELAY) : c_rep_w'(REPEAT_PERIOD);
    // Counting only continues while the FSM remains in IDLE_HIGH, so entering WAIT_LOW clears it.
    assign w_rep_hold   = (r_state == ST_IDLE_HIGH) && (w_state_nxt == ST_IDLE_HIGH);

    // Hold-to-repeat counter and strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rep_cnt    <= '0;
            r_rep_first  <= 1'b1;
            repeat_pulse <= 1'b0;
        end else if (!w_rep_hold) begin
            r_rep_cnt    <= '0;
            r_rep_first  <= 1'b1;
            repeat_pulse <= 1'b0;
        end else if (r_rep_cnt == w_rep_target) begin
            r_rep_cnt    <= c_rep_w'(1);
            r_rep_first  <= 1'b0;
            repeat_pulse <= 1'b1;
        end else begin
            r_rep_cnt    <= r_rep_cnt + 1'b1;
            repeat_pulse <= 1'b0;
        end
    end
`else
    logic w_unused_rep_params;
    assign w_unused_rep_params = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
    assign repeat_pulse        = 1'b0;
`endif

endmodule
`default_nettype wire
